store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
- Store-path counterpart to the 16->32 sign extender: narrows a 32-bit register value to byte, halfword or word for SB/SH/SW.
- Places the narrowed value on little-endian byte lanes and generates byte enables.
- Buffers results in a small FIFO between the EX/MEM stage and the data-memory write port, with valid/ready handshakes on both sides.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  store request valid.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  32  register value to store.
- in_addr  input  32  byte address.
- in_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- out_valid  output  1  head entry valid.
- out_ready  input  1  memory accepts head entry.
- out_addr  output  32  word-aligned address {in_addr[31:2],2'b00}.
- out_wdata  output  32  lane-replicated write data.
- out_be  output  4  byte enables, bit k = byte lane k.
- out_err  output  1  misaligned or illegal-size request.
- out_ovf  output  1  value not representable in the signed target width.
- err_count  output  ERRW  saturating count of accepted errored requests.

Behaviour:
- Reset (async assert, sync-style release): FIFO empty; out_valid=0; in_ready=1; err_count=0.
- Reset: out_addr/out_wdata/out_be/out_err/out_ovf are 0 while empty.
- Reset mid-operation discards all buffered entries.
- Accept: handshake when in_valid && in_ready; request is formatted combinationally, then written to the tail.
- Pop: when out_valid && out_ready.
- in_ready = (count < DEPTH). It is a function of registered count only; there is no combinational path from out_ready.
- When full, in_ready=0 even if out_ready=1 that cycle.
- Latency: accepted in cycle N -> visible at head in cycle N+1 if the FIFO was empty. No bypass.
- Simultaneous push and pop when not full: count unchanged; order preserved.
- Outputs reflect the head entry. The head holds stable while out_valid && !out_ready.
- Byte lanes and enables:
  - Byte: wdata = {4{in_data[7:0]}}; be = 1 << addr[1:0].
  - Half: wdata = {2{in_data[15:0]}}; addr[0] must be 0; addr[1]=0 -> be 0011, addr[1]=1 -> be 1100.
  - Word: wdata = in_data; addr[1:0] must be 00; be 1111.
- Error: misaligned half/word, or in_size=11 -> out_err=1 and be=0000. wdata is formatted as above for size 00-10, and 0 for size 11.
- Errored entries still flow through the FIFO in order. Memory must not write them (be=0).
- Overflow (informational, never blocks, never sets err):
  - byte: in_data[31:8] != {24{in_data[7]}}
  - half: in_data[31:16] != {16{in_data[15]}}
  - word or illegal size: 0
- err_count increments on each accepted errored request and saturates at all ones.
- Count/pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Test Plan:
- Reset/idle: rst_n low mid-transfer with 2 entries queued -> immediately out_valid=0, in_ready=1, err_count=0; entries lost after release.
- Byte store: data=0x12345680, addr=0x00001003, size=00 -> next cycle out_addr=0x00001000, wdata=0x80808080, be=1000, err=0, ovf=1 (upper bits not sign of 0x80).
- Half store: data=0xFFFF8001, addr=0x20000006, size=01 -> wdata=0x80018001, be=1100, ovf=0. Same data with addr=0x20000005 -> be=0000, err=1, err_count=1.
- Word and illegal size:
  - data=0xDEADBEEF, addr=0x10, size=10 -> wdata=0xDEADBEEF, be=1111.
  - addr=0x12, size=10 -> err=1.
  - size=11 -> err=1, wdata=0.
- Backpressure/full: out_ready=0, push 3 requests back-to-back -> third stalls (in_ready=0 after 2 accepts); head stable. Raise out_ready -> entries drain in order 1,2,3; in_ready=1 the cycle after the first pop.
- Saturation/throughput:
  - 300 misaligned halfword stores with ERRW=8 -> err_count=255.
  - Continuous valid with out_ready=1 -> one accept and one pop per cycle; count constant.

Source files
------------

// File: rtl/store_narrow_unit.sv
// Store-path narrowing unit: formats SB/SH/SW data onto little-endian byte lanes with byte
// enables, then buffers the formatted requests in a small FIFO toward the data-memory port.
module store_narrow_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic [31:0]     in_addr,
    input  logic [1:0]      in_size,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_addr,
    output logic [31:0]     out_wdata,
    output logic [3:0]      out_be,
    output logic            out_err,
    output logic            out_ovf,
    output logic [ERRW-1:0] err_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FullCnt = (PW + 1)'(DEPTH);

    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic        fmt_err;
    logic        fmt_ovf;

    always_comb begin
        fmt_wdata = '0;
        fmt_be    = '0;
        fmt_err   = 1'b0;
        fmt_ovf   = 1'b0;
        case (in_size)
            2'b00: begin
                fmt_wdata = {4{in_data[7:0]}};
                fmt_be    = 4'b0001 << in_addr[1:0];
                fmt_ovf   = in_data[31:8] != {24{in_data[7]}};
            end
            2'b01: begin
                fmt_wdata = {2{in_data[15:0]}};
                fmt_ovf   = in_data[31:16] != {16{in_data[15]}};
                if (in_addr[0]) begin
                    fmt_err = 1'b1;
                end else begin
                    fmt_be = in_addr[1] ? 4'b1100 : 4'b0011;
                end
            end
            2'b10: begin
                fmt_wdata = in_data;
                if (in_addr[1:0] != 2'b00) begin
                    fmt_err = 1'b1;
                end else begin
                    fmt_be = 4'b1111;
                end
            end
            default: begin
                fmt_err = 1'b1;
            end
        endcase
    end

    logic [29:0] mem_addr  [DEPTH];
    logic [31:0] mem_wdata [DEPTH];
    logic [3:0]  mem_be    [DEPTH];
    logic        mem_err   [DEPTH];
    logic        mem_ovf   [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic            push, pop;

    // in_ready depends only on registered count, so a full FIFO stalls even while popping.
    assign in_ready  = count_q < FullCnt;
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign err_count = err_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (push && fmt_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q]  <= in_addr[31:2];
            mem_wdata[wr_ptr_q] <= fmt_wdata;
            mem_be[wr_ptr_q]    <= fmt_be;
            mem_err[wr_ptr_q]   <= fmt_err;
            mem_ovf[wr_ptr_q]   <= fmt_ovf;
        end
    end

    always_comb begin
        out_addr  = '0;
        out_wdata = '0;
        out_be    = '0;
        out_err   = 1'b0;
        out_ovf   = 1'b0;
        if (out_valid) begin
            out_addr  = {mem_addr[rd_ptr_q], 2'b00};
            out_wdata = mem_wdata[rd_ptr_q];
            out_be    = mem_be[rd_ptr_q];
            out_err   = mem_err[rd_ptr_q];
            out_ovf   = mem_ovf[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: queue-based reference model checked every cycle, plus
// directed literal cases, backpressure, saturation and mid-operation reset.
module tb_store_narrow_unit;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned ERRW  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic [31:0]     in_addr;
    logic [1:0]      in_size;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_addr;
    logic [31:0]     out_wdata;
    logic [3:0]      out_be;
    logic            out_err;
    logic            out_ovf;
    logic [ERRW-1:0] err_count;

    always #5 clk = ~clk;

    store_narrow_unit #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_size   (in_size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_wdata (out_wdata),
        .out_be    (out_be),
        .out_err   (out_err),
        .out_ovf   (out_ovf),
        .err_count (err_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic        ovf;
    } ent_t;

    ent_t        q[$];
    int unsigned m_err;
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference formatting from access size in bytes and address modulo arithmetic.
    function automatic ent_t model_fmt(input logic [31:0] data, input logic [31:0] addr,
                                       input logic [1:0] size);
        ent_t    e;
        int      bytes;
        longint  sv;
        longint  lim;
        e.addr  = addr & 32'hFFFF_FFFC;
        e.wdata = '0;
        e.be    = '0;
        e.err   = 1'b1;
        e.ovf   = 1'b0;
        if (size == 2'b11) return e;
        bytes = 1 << size;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = data[8*(i % bytes) +: 8];
        e.err = (addr % bytes) != 0;
        e.be  = e.err ? 4'b0000 : 4'(((1 << bytes) - 1) << (addr % 4));
        if (bytes < 4) begin
            sv    = longint'($signed(data));
            lim   = longint'(1) << (8 * bytes - 1);
            e.ovf = (sv < -lim) || (sv >= lim);
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        ent_t e;
        bit   push;
        bit   pop;
        if (!rst_n) begin
            q.delete();
            m_err = 0;
        end else begin
            push = in_valid && (q.size() < DEPTH);
            pop  = out_ready && (q.size() > 0);
            e    = model_fmt(in_data, in_addr, in_size);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                if (e.err && m_err < 255) m_err++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("err_count", 32'(err_count), m_err);
            if (q.size() != 0) begin
                chk("out_addr", out_addr, q[0].addr);
                chk("out_wdata", out_wdata, q[0].wdata);
                chk("out_be", 32'(out_be), 32'(q[0].be));
                chk("out_err", 32'(out_err), 32'(q[0].err));
                chk("out_ovf", 32'(out_ovf), 32'(q[0].ovf));
            end else begin
                chk("idle_outputs", {out_addr ^ out_wdata, out_be, out_err, out_ovf}, 32'd0);
            end
        end
    end

    task automatic directed(input string name, input logic [31:0] d, input logic [31:0] a,
                            input logic [1:0] s, input logic [31:0] e_addr,
                            input logic [31:0] e_wdata, input logic [3:0] e_be,
                            input logic e_err, input logic e_ovf);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_addr   = a;
        in_size   = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_addr"}, out_addr, e_addr);
        chk({name, "_wdata"}, out_wdata, e_wdata);
        chk({name, "_be"}, 32'(out_be), 32'(e_be));
        chk({name, "_err"}, 32'(out_err), 32'(e_err));
        chk({name, "_ovf"}, 32'(out_ovf), 32'(e_ovf));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        in_size   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        directed("byte", 32'h1234_5680, 32'h0000_1003, 2'b00, 32'h0000_1000, 32'h8080_8080,
                 4'b1000, 1'b0, 1'b1);
        directed("half", 32'hFFFF_8001, 32'h2000_0006, 2'b01, 32'h2000_0004, 32'h8001_8001,
                 4'b1100, 1'b0, 1'b0);
        directed("half_mis", 32'hFFFF_8001, 32'h2000_0005, 2'b01, 32'h2000_0004,
                 32'h8001_8001, 4'b0000, 1'b1, 1'b0);
        chk("err_count_1", 32'(err_count), 32'd1);
        directed("word", 32'hDEAD_BEEF, 32'h0000_0010, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF,
                 4'b1111, 1'b0, 1'b0);
        directed("word_mis", 32'hDEAD_BEEF, 32'h0000_0012, 2'b10, 32'h0000_0010,
                 32'hDEAD_BEEF, 4'b0000, 1'b1, 1'b0);
        directed("illegal", 32'hDEAD_BEEF, 32'h0000_0010, 2'b11, 32'h0000_0010, 32'h0,
                 4'b0000, 1'b1, 1'b0);
        chk("err_count_3", 32'(err_count), 32'd3);

        // Backpressure: two accepts fill the FIFO, the third request waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_size   = 2'b10;
        in_addr   = 32'h100;
        in_data   = 32'hAAAA_0001;
        @(posedge clk); #1;
        in_data = 32'hAAAA_0002;
        @(posedge clk); #1;
        in_data = 32'hAAAA_0003;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_wdata, 32'hAAAA_0001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_head", out_wdata, 32'hAAAA_0001);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain1", out_wdata, 32'hAAAA_0001);
        @(negedge clk);
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("drain2", out_wdata, 32'hAAAA_0002);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain3", out_wdata, 32'hAAAA_0003);
        @(posedge clk); #1;

        // Saturation with continuous valid and ready.
        in_valid = 1'b1;
        in_size  = 2'b01;
        for (int i = 0; i < 300; i++) begin
            in_data = $urandom;
            in_addr = {$urandom, 1'b1};
            @(posedge clk); #1;
            if (!in_ready) chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        chk("err_sat", 32'(err_count), 32'd255);
        in_valid = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = ($urandom_range(0, 1) != 0) ? $urandom
                                                    : 32'($signed($urandom_range(0, 511)) - 256);
            in_addr   = $urandom;
            in_size   = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end

        // Reset with two entries queued discards them.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_size   = 2'b01;
        in_addr   = 32'h3;
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
